fp8_add_arbiter: RTL and testbench
==================================

# fp8_add_arbiter

Round-robin arbiter and sequencer that shares one FP8 adder (1-4-3 sign/exponent/mantissa format, one registered cycle of latency, `ena`-gated output register) between `NREQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the adder's operand and enable pins. It captures the adder result and returns it with the winning requester's index over a valid/ready response channel. It sits between the requester front-ends and the single adder instance at top level.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default 3: width of `rsp_id`; must satisfy 2^IDW >= NREQ.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: request i presents an operand pair.
- `req_ready` out NREQ: one-hot; accept strobe for the granted requester.
- `req_a` in 8*NREQ: operand A; byte i belongs to requester i.
- `req_b` in 8*NREQ: operand B; byte i belongs to requester i.
- `rsp_valid` out 1: the result is presented.
- `rsp_ready` in 1: the consumer accepts the result.
- `rsp_data` out 8: FP8 sum.
- `rsp_id` out IDW: index of the requester that owns `rsp_data`.
- `add_a` out 8: adder operand A.
- `add_b` out 8: adder operand B.
- `add_ena` out 1: adder enable. While low, the adder clears its output register.
- `add_y` in 8: registered adder result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, CAPTURE, RESP. Reset state is IDLE.
- **IDLE:**
  - If any `req_valid` is high, pick grant g (see below) and drive `req_ready[g]`=1 combinationally. All other `req_ready` bits are 0.
  - On that edge, latch `req_a[g]`, `req_b[g]` and g, advance the pointer to g, and go to ISSUE.
  - If no `req_valid` is high, stay in IDLE.
- **ISSUE:** drive `add_a`/`add_b` from the latched operands with `add_ena`=1. The adder registers the sum at the end of this cycle. Always go to CAPTURE.
- **CAPTURE:** `add_ena`=0 and the operands are held. Register `rsp_data`<=`add_y` and `rsp_id`<=g. Go to RESP.
- **RESP:**
  - `rsp_valid`=1.
  - If `rsp_ready`=1, go to IDLE on this edge; otherwise hold in RESP with `rsp_data`/`rsp_id` stable.
  - No new request is accepted while in RESP.
- **Grant:** search from index (pointer+1) mod NREQ upward and take the first requester with `req_valid` high. The pointer resets to NREQ-1, so requester 0 wins first. The pointer updates only on an accept.
- **Requester rule:** `req_valid` and the operands must stay stable until `req_ready`. Dropping `req_valid` before grant withdraws the request with no side effect.
- **Data path:** the operands pass through unmodified. Special encodings (exponent 1111) are handled by the adder, and the arbiter does not inspect them.
- **Reset values:** `req_ready`=0, `rsp_valid`=0, `rsp_data`=0x00, `rsp_id`=0, `add_a`=`add_b`=0x00, `add_ena`=0, `busy`=0, pointer=NREQ-1.
- **Reset mid-operation:** the in-flight operation is discarded and no response is produced. The FSM returns to IDLE asynchronously.

## Timing
- **Accept to response:** an accept at edge k gives `rsp_valid`=1 in the cycle after edge k+2, i.e. 3 cycles latency.
- **Throughput:** one operation per 4 cycles when `rsp_ready` is held at 1.
- **Combinational paths:** `req_ready` is combinational from `req_valid` and the FSM state. All other outputs are registered.
- **Response stall:** with `rsp_ready`=0, the block stalls indefinitely in RESP. The `req_valid` bits of other requesters are ignored during the stall.

## Configuration
- **`FP8_ARB_RR_EN` defined:** grant uses the rotating pointer described above.
- **`FP8_ARB_RR_EN` undefined:**
  - Grant uses fixed priority: the lowest index with `req_valid`=1 always wins.
  - The pointer register is not instantiated.
  - All other behaviour and timing are identical.

## Test plan
- **Basic add:** requester 0 sends a=0x38, b=0x38 and `rsp_ready` is held at 1. Required: `req_ready[0]` pulses for 1 cycle, then 3 cycles later `rsp_valid`=1 with `rsp_data`=0x40, `rsp_id`=0.
- **Exponent alignment:** requester 2 sends a=0x40, b=0x38. Required: `rsp_data`=0x44, `rsp_id`=2.
- **Fairness (`FP8_ARB_RR_EN` defined):**
  - Stimulus: all four `req_valid` held high.
  - Required: grants go 0,1,2,3,0, with accepts 4 cycles apart.
  - Without the macro, the same stimulus gives grants 0,0,0,...
- **Backpressure:** `rsp_ready`=0 for 10 cycles while in RESP. Required: `rsp_data`/`rsp_id` stay stable, `req_ready` stays 0, and the FSM returns to IDLE on the cycle `rsp_ready`=1.
- **Special value:** a=0x7A, b=0x38. Required: `rsp_data`=0x78, passed straight through from the adder.
- **Reset in CAPTURE:** assert `rst` asynchronously while in CAPTURE. Required: all outputs go to their reset values immediately, no `rsp_valid` appears, and the next grant goes to requester 0.

Source files
------------

// File: rtl/fp8_add_arbiter_if.sv
// fp8_add_arbiter_if
//   Bundles the request, response and adder-side signals of fp8_add_arbiter.
//   slave  : arbiter side (drives req_ready, rsp_*, add_a/add_b/add_ena, busy)
//   master : environment side (drives req_valid/req_a/req_b, rsp_ready, add_y)
//   Parameters: NREQ requesters (2..8), IDW bits of response index.
interface fp8_add_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [7:0]        rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        add_a;
  logic [7:0]        add_b;
  logic              add_ena;
  logic [7:0]        add_y;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, add_y,
    output req_ready, rsp_valid, rsp_data, rsp_id, add_a, add_b, add_ena, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, add_y,
    input  req_ready, rsp_valid, rsp_data, rsp_id, add_a, add_b, add_ena, busy
  );
endinterface

// File: rtl/fp8_add_arbiter.sv
// fp8_add_arbiter
//   Shares one registered FP8 (1-4-3) adder between NREQ requesters.
//   Sequence per operation: IDLE (accept) -> ISSUE (add_ena=1) -> CAPTURE
//   (sample add_y) -> RESP (hold until rsp_ready).
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     bus.slave  : req_valid/req_ready/req_a/req_b request side,
//                  rsp_valid/rsp_ready/rsp_data/rsp_id response side,
//                  add_a/add_b/add_ena/add_y adder side, busy status
//   Configuration macro: FP8_ARB_RR_EN
//     defined   -> round-robin grant using a rotating pointer
//     undefined -> fixed priority, lowest index wins, no pointer register
//   req_ready is the only combinational output; everything else is a flop.
module fp8_add_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 3
) (
  input logic               clk,
  input logic               rst,
  fp8_add_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     add_a_q, add_a_d;
  logic [7:0]     add_b_q, add_b_d;
  logic           add_ena_q, add_ena_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [7:0]     rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           busy_q, busy_d;
`ifdef FP8_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;
`endif

  logic            any_valid;
  logic [IDW-1:0]  gnt_idx;
  logic            accept;
  logic [NREQ-1:0] req_ready;

  // Grant selection
  always_comb begin
    any_valid = 1'b0;
    gnt_idx   = '0;
`ifdef FP8_ARB_RR_EN
    // Search starts just above the last winner and wraps around.
    for (int unsigned off = 1; off <= NREQ; off++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + off) % NREQ;
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
`else
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_valid && bus.req_valid[i]) begin
        any_valid = 1'b1;
        gnt_idx   = IDW'(i);
      end
    end
`endif
  end

  // Reset is folded in so req_ready reads 0 while rst is held.
  assign accept = (state_q == S_IDLE) && any_valid && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_ena_d   = add_ena_q;
    gnt_id_d    = gnt_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    busy_d      = busy_q;
`ifdef FP8_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // The operand flops double as the latched request; they are
          // presented to the adder from the ISSUE cycle onward.
          add_a_d   = bus.req_a[8*gnt_idx +: 8];
          add_b_d   = bus.req_b[8*gnt_idx +: 8];
          add_ena_d = 1'b1;
          gnt_id_d  = gnt_idx;
          busy_d    = 1'b1;
`ifdef FP8_ARB_RR_EN
          ptr_d     = gnt_idx;
`endif
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        add_ena_d = 1'b0;
        state_d   = S_CAPTURE;
      end
      S_CAPTURE: begin
        rsp_data_d  = bus.add_y;
        rsp_id_d    = gnt_id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_ena_q   <= 1'b0;
      gnt_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      busy_q      <= 1'b0;
`ifdef FP8_ARB_RR_EN
      ptr_q       <= IDW'(NREQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_ena_q   <= add_ena_d;
      gnt_id_q    <= gnt_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= busy_d;
`ifdef FP8_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_ena   = add_ena_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fp8_add_arbiter.sv
// tb_fp8_add_arbiter
//   Self-checking bench for fp8_add_arbiter (NREQ=4, IDW=3) with a
//   behavioural registered FP8 adder attached to the add_* pins.
//   Fairness expectations follow FP8_ARB_RR_EN.
module tb_fp8_add_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 3;

  logic clk;
  logic rst;

  fp8_add_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fp8_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FP8 1-4-3 adder (bias 7), truncating.
  function automatic logic [7:0] fp8_add_model(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, t;
    int ea, eb, ma, mb, m, e;
    a = a_in;
    b = b_in;
    if (a[6:3] == 4'hF) return {a[7], 4'hF, 3'b000};
    if (b[6:3] == 4'hF) return {b[7], 4'hF, 3'b000};
    if (b[6:0] > a[6:0]) begin
      t = a; a = b; b = t;
    end
    ea = (a[6:3] == 4'h0) ? 1 : int'(a[6:3]);
    eb = (b[6:3] == 4'h0) ? 1 : int'(b[6:3]);
    ma = int'({a[6:3] != 4'h0, a[2:0]});
    mb = int'({b[6:3] != 4'h0, b[2:0]});
    mb = mb >> (ea - eb);
    m  = (a[7] == b[7]) ? (ma + mb) : (ma - mb);
    e  = ea;
    if (m == 0) return 8'h00;
    if (m >= 16) begin
      m = m >> 1;
      e = e + 1;
    end
    while (m < 8 && e > 1) begin
      m = m << 1;
      e = e - 1;
    end
    if (m < 8) e = 0;
    if (e >= 15) return {a[7], 4'hF, 3'b000};
    return {a[7], e[3:0], m[2:0]};
  endfunction

  always @(posedge clk) begin
    bus.add_y <= bus.add_ena ? fp8_add_model(bus.add_a, bus.add_b) : 8'h00;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     data;
  } exp_t;

  exp_t sbq[$];

  // Response monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sbq.size() == 0) begin
        chk(1'b0, "unexpected_rsp", {bus.rsp_id, bus.rsp_data}, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk(bus.rsp_id == e.id, "rsp_id", bus.rsp_id, e.id);
        chk(bus.rsp_data == e.data, "rsp_data", bus.rsp_data, e.data);
      end
    end
  end

  typedef struct {
    int unsigned id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  y;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [NREQ-1:0] onehot(input int unsigned i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_op(input int unsigned id, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] y);
    bit got;
    bit seen;
    int n;
    @(posedge clk);
    #1;
    bus.req_valid = onehot(id);
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_a[8*id +: 8] = a;
    bus.req_b[8*id +: 8] = b;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (bus.req_ready != '0) got = 1'b1;
    end
    if (!got) begin
      chk(1'b0, "accept_timeout", 0, id);
      bus.req_valid = '0;
    end else begin
      chk(bus.req_ready == onehot(id), "req_ready", bus.req_ready, onehot(id));
      sbq.push_back('{id: IDW'(id), data: y});
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      n = 0;
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        @(negedge clk);
        n++;
        if (bus.rsp_valid) seen = 1'b1;
      end
      chk(seen && n == 3, "latency", n, 3);
    end
  endtask

  task automatic drain();
    for (int w = 0; w < 50 && sbq.size() != 0; w++) @(negedge clk);
    chk(sbq.size() == 0, "drain", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned exp_g[5];
    int unsigned g;
    int gap;
    bit got;
    logic [7:0] held_data;

    vecs[0] = '{0, 8'h38, 8'h38, 8'h40};  // 1 + 1
    vecs[1] = '{2, 8'h40, 8'h38, 8'h44};  // 2 + 1, exponent alignment
    vecs[2] = '{1, 8'h7A, 8'h38, 8'h78};  // special operand
    vecs[3] = '{3, 8'h30, 8'h38, 8'h3C};  // 0.5 + 1
    vecs[4] = '{1, 8'hB8, 8'h40, 8'h38};  // -1 + 2
    vecs[5] = '{0, 8'h00, 8'h00, 8'h00};  // zeros
    vecs[6] = '{3, 8'h77, 8'h77, 8'h78};  // overflow
    vecs[7] = '{2, 8'h01, 8'h01, 8'h02};  // subnormals
    vecs[8] = '{2, 8'h38, 8'hB8, 8'h00};  // exact cancellation

`ifdef FP8_ARB_RR_EN
    exp_g = '{0, 1, 2, 3, 0};
`else
    exp_g = '{0, 0, 0, 0, 0};
`endif

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk(bus.req_ready == '0, "rst_req_ready", bus.req_ready, 0);
    chk(bus.rsp_valid == 1'b0, "rst_rsp_valid", bus.rsp_valid, 0);
    chk(bus.rsp_data == 8'h00, "rst_rsp_data", bus.rsp_data, 0);
    chk(bus.rsp_id == '0, "rst_rsp_id", bus.rsp_id, 0);
    chk({bus.add_a, bus.add_b} == 16'h0, "rst_add_ops", {bus.add_a, bus.add_b}, 0);
    chk(bus.add_ena == 1'b0, "rst_add_ena", bus.add_ena, 0);
    chk(bus.busy == 1'b0, "rst_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fairness: all requesters held valid from reset
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    bus.req_a = {NREQ{8'h38}};
    bus.req_b = {NREQ{8'h38}};
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      gap = 0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        gap++;
        if (bus.req_ready != '0) got = 1'b1;
      end
      if (!got) begin
        chk(1'b0, "fair_timeout", 0, exp_g[k]);
      end else begin
        g = 0;
        for (int unsigned i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
        chk(bus.req_ready == onehot(exp_g[k]), "fair_grant", bus.req_ready, onehot(exp_g[k]));
        if (k > 0) chk(gap == 4, "fair_spacing", gap, 4);
        sbq.push_back('{id: IDW'(g), data: 8'h40});
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    drain();

    // Table-driven operations
    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].y);
    end
    drain();

    // Backpressure: hold RESP for 10 cycles with another requester waiting
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    do_op(1, 8'h38, 8'h30, 8'h3C);
    held_data = 8'h3C;
    @(posedge clk);
    #1;
    bus.req_valid = onehot(3);
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_a[8*3 +: 8] = 8'h40;
    bus.req_b[8*3 +: 8] = 8'h40;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk(bus.rsp_valid && bus.rsp_data == held_data && bus.rsp_id == 3'd1 &&
          bus.req_ready == '0 && bus.busy,
          "stall_hold", {bus.rsp_valid, bus.busy, bus.rsp_id, bus.rsp_data, bus.req_ready},
          {1'b1, 1'b1, 3'd1, held_data, 4'b0000});
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk(!bus.busy && !bus.rsp_valid && bus.req_ready == onehot(3), "stall_release",
        {bus.busy, bus.rsp_valid, bus.req_ready}, {2'b00, onehot(3)});
    if (bus.req_ready == onehot(3)) sbq.push_back('{id: 3'd3, data: 8'h48});
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    drain();

    // Reset while in CAPTURE
    @(posedge clk);
    #1;
    bus.req_valid = onehot(2);
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_a[8*2 +: 8] = 8'h40;
    bus.req_b[8*2 +: 8] = 8'h40;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (bus.req_ready != '0) got = 1'b1;
    end
    chk(got, "rstcap_accept", got, 1);
    @(posedge clk);          // accept -> ISSUE
    #1;
    bus.req_valid = '0;
    @(posedge clk);          // ISSUE -> CAPTURE
    #2;
    chk(bus.busy && bus.add_a == 8'h40, "rstcap_pre", {bus.busy, bus.add_a}, {1'b1, 8'h40});
    rst = 1'b1;
    #1;
    chk(bus.req_ready == '0 && !bus.rsp_valid && bus.rsp_data == 8'h00 && bus.rsp_id == '0 &&
        bus.add_a == 8'h00 && bus.add_b == 8'h00 && !bus.add_ena && !bus.busy,
        "rstcap_outputs",
        {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.add_a, bus.add_b,
         bus.add_ena, bus.busy}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gap = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) gap++;
    end
    chk(gap == 0, "rstcap_no_rsp", gap, 0);
    @(posedge clk);
    #1;
    bus.req_valid = '1;
    bus.req_a = {NREQ{8'h38}};
    bus.req_b = {NREQ{8'h38}};
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (bus.req_ready != '0) got = 1'b1;
    end
    chk(bus.req_ready == onehot(0), "rstcap_next_grant", bus.req_ready, onehot(0));
    if (got) begin
      g = 0;
      for (int unsigned i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
      sbq.push_back('{id: IDW'(g), data: 8'h40});
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
